instr_fetch_unit: RTL and testbench

//  Front-end stage directly upstream of the immediate generator and decoder.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two fetch buffer of {instr, pc} entries.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_C);
    assign w_pop   = i_pop & ~w_empty & ~i_flush;
    // a push into a full buffer is only legal when the head leaves in the same cycle
    assign w_push  = i_push & (~w_full | w_pop) & ~i_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC holder and instruction-memory requester feeding decode through a fetch buffer.
// Optional FETCH_PERF_CNT_EN adds fetch_count/flush_count performance counters.
//
// state | meaning
// IDLE  | no request on the memory port; buffer has no free slot
// REQ   | imem_req high at imem_addr, waiting for imem_ack
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [XLEN-1:0]    instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        flush_count
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_imem_addr;
    logic            r_drop;

    fetch_state_t    w_state_next;
    logic [XLEN-1:0] w_fetch_pc_next;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_ack;
    logic            w_hold;
    logic            w_push;
    logic            w_pop;

    assign w_ack  = (r_state == REQ) & imem_ack;
    assign w_hold = (r_state == REQ) & ~imem_ack;
    assign w_push = w_ack & ~r_drop & ~redirect_valid;
    assign w_pop  = instr_valid & instr_ready;

    assign w_push_data.instr = imem_rdata;
    assign w_push_data.pc    = r_fetch_pc;

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_data(w_push_data),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (redirect_valid) begin
            w_fetch_pc_next = align_pc(redirect_pc);
        end else if (w_ack && !r_drop) begin
            w_fetch_pc_next = r_fetch_pc + PC_STEP;
        end
    end

    // occupancy after this cycle's push/pop/flush decides whether another request fits
    always_comb begin
        w_count_next = w_count;
        if (redirect_valid) begin
            w_count_next = '0;
        end else begin
            w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_comb begin
        w_state_next = IDLE;
        if (w_hold || (w_count_next < DEPTH_C)) begin
            w_state_next = REQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_imem_addr <= RESET_PC;
            r_drop      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            // the address of an in-flight request never moves, even across a redirect
            if (!w_hold) begin
                r_imem_addr <= w_fetch_pc_next;
            end
            if (redirect_valid) begin
                r_drop <= w_hold;
            end else if (w_ack) begin
                r_drop <= 1'b0;
            end
        end
    end

    assign imem_req    = (r_state == REQ);
    assign imem_addr   = r_imem_addr;
    assign instr_valid = (w_count != '0);
    assign instruction = instr_valid ? w_head.instr : '0;
    assign instr_pc    = instr_valid ? w_head.pc    : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_pop && !redirect_valid) r_fetch_count <= r_fetch_count + 32'd1;
            if (redirect_valid)           r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based reference model,
// memory responder with variable ack delay, directed cases then random traffic.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int              DEPTH = 2;
    localparam logic [63:0]     RPC   = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    instr_fetch_unit #(
        .RESET_PC      (RPC),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .instr_pc      (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .flush_count   (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    fetch_entry_t m_q[$];
    logic [63:0]  m_fetch_pc;
    logic [63:0]  m_addr;
    bit           m_req;
    bit           m_drop;
    logic [31:0]  m_pops;
    logic [31:0]  m_flushes;

    // memory responder state
    logic [31:0]  mem_base;
    int           delay_max;
    bit           delay_rand;
    int           cur_delay;
    int           wcnt;
    bit           spurious_en;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return mem_base + a[33:2];
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc = RPC;
        m_addr     = RPC;
        m_req      = 1'b0;
        m_drop     = 1'b0;
        m_pops     = '0;
        m_flushes  = '0;
    endtask

    // one clock of the front end, stated as queue operations
    task automatic model_update(input bit rdy, input bit redir, input logic [63:0] rpc, input bit ack);
        bit accepted;
        bit in_flight;
        bit pop;
        accepted  = m_req && ack;
        in_flight = m_req && !ack;
        pop       = (m_q.size() > 0) && rdy && !redir;
        if (redir) begin
            m_q.delete();
            m_flushes++;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            if (accepted && !m_drop) m_q.push_back('{instr: mem_word(m_addr), pc: m_addr});
        end
        if (redir)                     m_fetch_pc = {rpc[63:2], 2'b00};
        else if (accepted && !m_drop)  m_fetch_pc = m_fetch_pc + 64'd4;
        if (redir)         m_drop = in_flight;
        else if (accepted) m_drop = 1'b0;
        if (!in_flight) begin
            m_req  = (m_q.size() < DEPTH);
            m_addr = m_fetch_pc;
        end
    endtask

    task automatic compare_all();
        check64("imem_req", 64'(imem_req), 64'(m_req));
        check64("imem_addr", imem_addr, m_addr);
        check64("instr_valid", 64'(instr_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check64("instruction", 64'(instruction), 64'(m_q[0].instr));
            check64("instr_pc", instr_pc, m_q[0].pc);
        end
`ifdef FETCH_PERF_CNT_EN
        check64("fetch_count", 64'(fetch_count), 64'(m_pops));
        check64("flush_count", 64'(flush_count), 64'(m_flushes));
`endif
    endtask

    // called at a falling edge: drive, advance one rising edge, compare at next falling edge
    task automatic step(input bit rdy, input bit redir, input logic [63:0] rpc);
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (imem_req) begin
            if (wcnt >= cur_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wcnt       = 0;
                cur_delay  = delay_rand ? int'($urandom_range(delay_max, 0)) : delay_max;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wcnt++;
            end
        end else begin
            imem_ack   = spurious_en;
            imem_rdata = $urandom;
            wcnt       = 0;
        end
        @(posedge clk);
        model_update(rdy, redir, rpc, imem_ack);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input bit with_ack);
        reset          = 1'b1;
        imem_ack       = with_ack;
        imem_rdata     = $urandom;
        redirect_valid = 1'b0;
        #1;
        check64("rst_imem_req", 64'(imem_req), 64'd0);
        check64("rst_imem_addr", imem_addr, RPC);
        check64("rst_instr_valid", 64'(instr_valid), 64'd0);
        check64("rst_instruction", 64'(instruction), 64'd0);
        check64("rst_instr_pc", instr_pc, 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        imem_ack  = 1'b0;
        wcnt      = 0;
        cur_delay = delay_max;
        compare_all();
    endtask

    function automatic logic [63:0] junk();
        return {$urandom, $urandom};
    endfunction

    initial begin
        bit          found;
        logic [63:0] rpc;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b0;
        spurious_en    = 1'b0;
        delay_rand     = 1'b0;
        delay_max      = 0;
        cur_delay      = 0;
        wcnt           = 0;
        mem_base       = 32'h0;
        model_reset();
        @(negedge clk);

        // 1: zero-wait memory, words are PC>>2
        do_reset(1'b0);
        step(1'b1, 1'b0, junk());
        check64("t1_valid_c1", 64'(instr_valid), 64'd0);
        check64("t1_addr_c1", imem_addr, 64'h0);
        step(1'b1, 1'b0, junk());
        check64("t1_valid_c2", 64'(instr_valid), 64'd1);
        check64("t1_pc0", instr_pc, 64'h0);
        check64("t1_addr_c2", imem_addr, 64'h4);
        step(1'b1, 1'b0, junk());
        check64("t1_pc1", instr_pc, 64'h4);
        check64("t1_ins1", 64'(instruction), 64'h1);
        step(1'b1, 1'b0, junk());
        check64("t1_pc2", instr_pc, 64'h8);
        check64("t1_ins2", 64'(instruction), 64'h2);

        // 2: decode stalled for 5 cycles
        mem_base = 32'h13;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, junk());
        check64("t2_model_count", 64'(m_q.size()), 64'd2);
        check64("t2_req_low", 64'(imem_req), 64'd0);
        check64("t2_head_ins", 64'(instruction), 64'h13);
        check64("t2_head_pc", instr_pc, 64'h0);
        step(1'b1, 1'b0, junk());
        check64("t2_drain_pc", instr_pc, 64'h4);
        check64("t2_drain_ins", 64'(instruction), 64'h14);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, junk());

        // 3: redirect while a slow request is outstanding
        mem_base  = 32'h100;
        delay_max = 3;
        do_reset(1'b0);
        step(1'b1, 1'b0, junk());
        step(1'b1, 1'b1, 64'h1002);
        check64("t3_addr_held", imem_addr, 64'h0);
        check64("t3_req_held", 64'(imem_req), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, junk());
        check64("t3_new_addr", imem_addr, 64'h1000);
        check64("t3_no_stale", 64'(instr_valid), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, junk());
            if (instr_valid) begin
                found = 1'b1;
                check64("t3_first_pc", instr_pc, 64'h1000);
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL t3_timeout actual=no_valid required=valid_within_20");
        end

        // 4: redirect coinciding with ack and pop
        mem_base  = 32'h200;
        delay_max = 0;
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, junk());
        step(1'b1, 1'b1, 64'h8006);
        check64("t4_valid_drop", 64'(instr_valid), 64'd0);
        check64("t4_addr", imem_addr, 64'h8004);
        step(1'b1, 1'b0, junk());
        check64("t4_first_pc", instr_pc, 64'h8004);
        check64("t4_first_ins", 64'(instruction), 64'h200 + 64'h2001);

        // 5: reset mid-request with an ack in the reset cycle, stale ack afterwards
        mem_base  = 32'h300;
        delay_max = 3;
        do_reset(1'b0);
        step(1'b1, 1'b0, junk());
        step(1'b1, 1'b0, junk());
        do_reset(1'b1);
        spurious_en = 1'b1;
        step(1'b1, 1'b0, junk());
        spurious_en = 1'b0;
        check64("t5_req", 64'(imem_req), 64'd1);
        check64("t5_addr", imem_addr, RPC);
        check64("t5_valid", 64'(instr_valid), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, junk());
            if (instr_valid) begin
                found = 1'b1;
                check64("t5_first_pc", instr_pc, RPC);
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL t5_timeout actual=no_valid required=valid_within_20");
        end

`ifdef FETCH_PERF_CNT_EN
        // 6: performance counters
        mem_base  = 32'h400;
        delay_max = 0;
        do_reset(1'b0);
        for (int i = 0; i < 60 && m_pops < 10; i++) step(1'b1, 1'b0, junk());
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'h2000 + 64'(i * 16));
        check64("t6_fetch_count", 64'(fetch_count), 64'd10);
        check64("t6_flush_count", 64'(flush_count), 64'd3);
`endif

        // random traffic: stalls, redirects (some near the top of the address space), late acks, resets
        mem_base   = $urandom;
        delay_rand = 1'b1;
        delay_max  = 2;
        do_reset(1'b0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(199, 0) == 0) begin
                do_reset(1'($urandom_range(1, 0)));
            end else begin
                spurious_en = ($urandom_range(3, 0) == 0);
                if ($urandom_range(3, 0) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
                else                           rpc = junk();
                step($urandom_range(3, 0) != 0, $urandom_range(14, 0) == 0, rpc);
            end
        end
        spurious_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
